// File: rtl/apb_slave_regbank.sv
// APB completer with eight word registers: ID, CTRL, five scratch words and a
// write counter. Wait states are fixed by parameter; decode errors on pslverr.
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for a SETUP phase
// ACCESS | transfer captured, counting wait states, completes when pready=1
module apb_slave_regbank #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001,
    parameter logic [31:0] CTRL_RESET  = 32'h0000_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] ctrl_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        setup_take, commit, pready_int;

    logic [31:0] ctrl_q;
    logic [31:0] scratch_q [5];
    logic [31:0] wrcnt_q;

    logic [2:0]  idx_q;
    logic [31:0] wdata_q;
    logic        write_q, err_q;
    logic [31:0] rdata_q;

    logic [2:0]  idx_in;
    logic        addr_bad, setup_err;
    logic [31:0] rd_sel, rd_load;
    logic        write_ok;

    // Upper address bits are decoded by the bridge, not here.
    logic        unused_paddr;
    assign unused_paddr = ^paddr[31:12];

    assign idx_in    = paddr[4:2];
    assign addr_bad  = (paddr[1:0] != 2'b00) || (paddr[11:5] != 7'd0);
    assign setup_err = addr_bad || (pwrite && ((idx_in == 3'd0) || (idx_in == 3'd7)));

    always_comb begin
        rd_sel = '0;
        case (idx_in)
            3'd0: rd_sel = ID_VALUE;
            3'd1: rd_sel = ctrl_q;
            3'd2: rd_sel = scratch_q[0];
            3'd3: rd_sel = scratch_q[1];
            3'd4: rd_sel = scratch_q[2];
            3'd5: rd_sel = scratch_q[3];
            3'd6: rd_sel = scratch_q[4];
            3'd7: rd_sel = wrcnt_q;
            default: rd_sel = '0;
        endcase
    end

    assign rd_load = (!pwrite && !addr_bad) ? rd_sel : 32'd0;

    // pready comes only from registered state so the bridge sees no input path.
    assign pready_int = (state_q == ACCESS) && (wait_cnt_q == WAIT_LIMIT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        setup_take = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d    = ACCESS;
                    wait_cnt_d = '0;
                    setup_take = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable && pready_int) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end else if (!pready_int) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (setup_take) begin
            idx_q   <= idx_in;
            wdata_q <= pwdata;
            write_q <= pwrite;
            err_q   <= setup_err;
            rdata_q <= rd_load;
        end
    end

    assign write_ok = commit && write_q && !err_q;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            ctrl_q  <= CTRL_RESET;
            wrcnt_q <= '0;
            for (int i = 0; i < 5; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (write_ok) begin
            if (idx_q == 3'd1) begin
                ctrl_q <= wdata_q;
            end
            for (int i = 0; i < 5; i++) begin
                if (idx_q == 3'(i + 2)) begin
                    scratch_q[i] <= wdata_q;
                end
            end
            wrcnt_q <= wrcnt_q + 32'd1;
        end
    end

    assign pready   = pready_int;
    assign pslverr  = pready_int && err_q;
    assign prdata   = ((state_q == ACCESS) && !write_q) ? rdata_q : 32'd0;
    assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (0 and 3 wait states) driven by
// directed and random APB transfers, checked against an array-based register model.
module tb_apb_slave_regbank;

    localparam logic [31:0] ID_VAL     = 32'hA5B2_0001;
    localparam logic [31:0] CTRL_RST1  = 32'h0000_00C3;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];
    logic [31:0] ctrl_out [2];

    int tests = 0;
    int fails = 0;
    int ws_of [2] = '{0, 3};

    logic [31:0] m_reg [2][8];

    always #5 Hclk = ~Hclk;

    apb_slave_regbank #(.WAIT_STATES(0), .ID_VALUE(ID_VAL), .CTRL_RESET(32'h0)) u_ws0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .ctrl_out(ctrl_out[0])
    );

    apb_slave_regbank #(.WAIT_STATES(3), .ID_VALUE(ID_VAL), .CTRL_RESET(CTRL_RST1)) u_ws3 (
        .Hclk(Hclk), .Hresetn(Hresetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .ctrl_out(ctrl_out[1])
    );

    // Reference model: word 0 is ID, 1 CTRL, 2..6 scratch, 7 successful-write count.
    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_reg[d][i] = 32'd0;
            m_reg[d][0] = ID_VAL;
        end
        m_reg[1][1] = CTRL_RST1;
    endfunction

    function automatic void m_predict(input int d, input logic [31:0] a, input bit wr,
                                      output logic [31:0] rd, output bit err);
        bit bad;
        int idx;
        bad = (a[1:0] != 2'b00) || (a[11:5] != 7'd0);
        idx = int'(a[4:2]);
        err = bad || (wr && (idx == 0 || idx == 7));
        rd  = (!wr && !bad) ? m_reg[d][idx] : 32'd0;
    endfunction

    function automatic void m_commit(input int d, input logic [31:0] a, input bit wr,
                                     input logic [31:0] wd);
        logic [31:0] rd;
        bit err;
        m_predict(d, a, wr, rd, err);
        if (wr && !err) begin
            m_reg[d][int'(a[4:2])] = wd;
            m_reg[d][7] = m_reg[d][7] + 32'd1;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic xfer(input int d, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input bit hold, output logic [31:0] rd, output bit err,
                        output int waits, output logic [31:0] ctrl_pend);
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = wr; pwdata[d] = wd;
        @(posedge Hclk); #1;
        penable[d] = 1'b1;
        waits = 0;
        while (pready[d] !== 1'b1 && waits <= 40) begin
            waits++;
            @(posedge Hclk); #1;
        end
        rd = prdata[d];
        err = pslverr[d];
        ctrl_pend = ctrl_out[d];
        @(posedge Hclk); #1;
        penable[d] = 1'b0;
        if (!hold) psel[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            tests++; if (prdata[d] !== 32'd0) begin fails++; $display("FAIL reset_prdata[%0d] got %h exp 0", d, prdata[d]); end
            tests++; if (pready[d] !== 1'b0) begin fails++; $display("FAIL reset_pready[%0d] got %b exp 0", d, pready[d]); end
            tests++; if (pslverr[d] !== 1'b0) begin fails++; $display("FAIL reset_pslverr[%0d] got %b exp 0", d, pslverr[d]); end
            tests++; if (ctrl_out[d] !== m_reg[d][1]) begin fails++; $display("FAIL reset_ctrl_out[%0d] got %h exp %h", d, ctrl_out[d], m_reg[d][1]); end
        end
    endtask

    task automatic test_id_read();
        logic [31:0] rd, cp; bit err; int w;
        xfer(0, 32'h000, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'hA5B2_0001) begin fails++; $display("FAIL id_read got %h exp a5b20001", rd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL id_read_err got %b exp 0", err); end
        tests++; if (w !== 0) begin fails++; $display("FAIL id_read_waits got %0d exp 0", w); end
    endtask

    task automatic test_ctrl_write();
        logic [31:0] rd, cp, old; bit err; int w;
        old = m_reg[0][1];
        xfer(0, 32'h004, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, err, w, cp);
        m_commit(0, 32'h004, 1'b1, 32'hDEAD_BEEF);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ctrl_write_err got %b exp 0", err); end
        tests++; if (cp !== old) begin fails++; $display("FAIL ctrl_before_commit got %h exp %h", cp, old); end
        tests++; if (ctrl_out[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ctrl_out got %h exp deadbeef", ctrl_out[0]); end
        xfer(0, 32'h004, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ctrl_readback got %h exp deadbeef", rd); end
        xfer(0, 32'h01C, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'd1) begin fails++; $display("FAIL wrcnt_after_one got %h exp 1", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, cp, old; bit err; int w;
        xfer(1, 32'h008, 1'b1, 32'h1234_5678, 1'b0, rd, err, w, cp);
        m_commit(1, 32'h008, 1'b1, 32'h1234_5678);
        tests++; if (w !== 3) begin fails++; $display("FAIL ws3_waits got %0d exp 3", w); end
        xfer(1, 32'h008, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL ws3_scratch0 got %h exp 12345678", rd); end
        old = m_reg[1][1];
        xfer(1, 32'h004, 1'b1, 32'h0BAD_F00D, 1'b0, rd, err, w, cp);
        m_commit(1, 32'h004, 1'b1, 32'h0BAD_F00D);
        tests++; if (cp !== old) begin fails++; $display("FAIL ws3_ctrl_early got %h exp %h", cp, old); end
        tests++; if (ctrl_out[1] !== 32'h0BAD_F00D) begin fails++; $display("FAIL ws3_ctrl_after got %h exp 0badf00d", ctrl_out[1]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, cp; bit err; int w;
        logic [31:0] addrs [4] = '{32'h000, 32'h01C, 32'h022, 32'h040};
        bit          wrs [4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xfer(0, addrs[i], wrs[i], 32'hFFFF_0000, (i != 3), rd, err, w, cp);
            m_commit(0, addrs[i], wrs[i], 32'hFFFF_0000);
            tests++; if (err !== 1'b1 || w !== 0) begin fails++; $display("FAIL err_resp[%0d] got err=%b waits=%0d exp err=1 waits=0", i, err, w); end
            tests++; if (rd !== 32'd0) begin fails++; $display("FAIL err_rdata[%0d] got %h exp 0", i, rd); end
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 32'(i) << 2, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
            tests++; if (rd !== m_reg[0][i] || err !== 1'b0) begin fails++; $display("FAIL err_regs[%0d] got %h/%b exp %h/0", i, rd, err, m_reg[0][i]); end
        end
    endtask

    task automatic test_wrcnt_wrap();
        logic [31:0] rd, cp; bit err; int w;
        force u_ws0.wrcnt_q = 32'hFFFF_FFFF;
        #2;
        release u_ws0.wrcnt_q;
        m_reg[0][7] = 32'hFFFF_FFFF;
        xfer(0, 32'h01C, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrcnt_preload got %h exp ffffffff", rd); end
        xfer(0, 32'h010, 1'b1, 32'h5555_AAAA, 1'b0, rd, err, w, cp);
        m_commit(0, 32'h010, 1'b1, 32'h5555_AAAA);
        xfer(0, 32'h01C, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== m_reg[0][7] || rd !== 32'd0) begin fails++; $display("FAIL wrcnt_wrap got %h exp 0", rd); end
    endtask

    task automatic test_idle_enable();
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h00C; pwdata[0] = 32'h1;
        for (int i = 0; i < 2; i++) begin
            @(posedge Hclk); #1;
            tests++; if (pready[0] !== 1'b0) begin fails++; $display("FAIL idle_enable_pready[%0d] got %b exp 0", i, pready[0]); end
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge Hclk); #1;
    endtask

    task automatic test_abort();
        logic [31:0] rd, cp; bit err; int w;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h00C; pwdata[1] = 32'hCAFE_0001;
        @(posedge Hclk); #1;
        penable[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge Hclk); #1;
            tests++; if (pready[1] !== 1'b0) begin fails++; $display("FAIL abort_wait_pready[%0d] got %b exp 0", i, pready[1]); end
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge Hclk); #1;
        tests++; if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0) begin fails++; $display("FAIL abort_idle got pready=%b pslverr=%b exp 0/0", pready[1], pslverr[1]); end
        xfer(1, 32'h00C, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== m_reg[1][3]) begin fails++; $display("FAIL abort_no_write got %h exp %h", rd, m_reg[1][3]); end
        xfer(1, 32'h01C, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== m_reg[1][7]) begin fails++; $display("FAIL abort_wrcnt got %h exp %h", rd, m_reg[1][7]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, cp, a, wd, exp_rd; bit err, exp_err, wr, hold; int w, r;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 9);
                if (r < 8)       a = ($urandom & 32'hFFFF_F000) | (32'(r) << 2);
                else if (r == 8) a = ($urandom & 32'hFFFF_F01C) | 32'($urandom_range(1, 3));
                else             a = ($urandom & 32'hFFFF_F01F) | (32'($urandom_range(1, 127)) << 5);
                wr = 1'($urandom_range(0, 1));
                wd = $urandom;
                hold = (n != 59) && ($urandom_range(0, 1) == 1);
                m_predict(d, a, wr, exp_rd, exp_err);
                xfer(d, a, wr, wd, hold, rd, err, w, cp);
                m_commit(d, a, wr, wd);
                tests++;
                if (rd !== exp_rd || err !== exp_err || w !== ws_of[d] || ctrl_out[d] !== m_reg[d][1]) begin
                    fails++;
                    $display("FAIL rand[%0d][%0d] a=%h wr=%b got rd=%h err=%b waits=%0d ctrl=%h exp rd=%h err=%b waits=%0d ctrl=%h",
                             d, n, a, wr, rd, err, w, ctrl_out[d], exp_rd, exp_err, ws_of[d], m_reg[d][1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, cp; bit err; int w;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h004; pwdata[1] = 32'hFFFF_0000;
        @(posedge Hclk); #1;
        penable[1] = 1'b1;
        @(posedge Hclk); #1;
        Hresetn = 1'b0;
        m_reset();
        #1;
        tests++; if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata[1] !== 32'd0) begin fails++; $display("FAIL rstmid_outputs got pready=%b pslverr=%b prdata=%h exp 0/0/0", pready[1], pslverr[1], prdata[1]); end
        tests++; if (ctrl_out[1] !== CTRL_RST1) begin fails++; $display("FAIL rstmid_ctrl got %h exp %h", ctrl_out[1], CTRL_RST1); end
        tests++; if (ctrl_out[0] !== 32'd0) begin fails++; $display("FAIL rstmid_ctrl0 got %h exp 0", ctrl_out[0]); end
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        xfer(1, 32'h004, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== m_reg[1][1]) begin fails++; $display("FAIL rstmid_ctrl_read got %h exp %h", rd, m_reg[1][1]); end
        xfer(1, 32'h01C, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rstmid_wrcnt got %h exp 0", rd); end
        xfer(1, 32'h008, 1'b0, 32'd0, 1'b0, rd, err, w, cp);
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rstmid_scratch got %h exp 0", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
        end
        m_reset();
        Hresetn = 1'b0;
        #23;
        test_reset();
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        test_id_read();
        test_ctrl_write();
        test_wait_states();
        test_errors();
        test_wrcnt_wrap();
        test_idle_enable();
        test_abort();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
